// File: rtl/irq_source_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared constants and types for the interrupt source controller:
//   NUM_IRQ    - width of the core interrupt vector
//   IRQ_ID_W   - width of the taken-interrupt index returned by the core
//   cfg_sel_e  - configuration write target selector
//   IRQ_LEVEL / IRQ_EDGE - per-source mode bit values
//   impl_mask  - mask of implemented source bits for a given source count
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int NUM_IRQ  = 32;
  localparam int IRQ_ID_W = 5;

  typedef enum logic [1:0] {
    CFG_ENABLE   = 2'd0,
    CFG_MODE     = 2'd1,
    CFG_PEND_SET = 2'd2,
    CFG_PEND_CLR = 2'd3
  } cfg_sel_e;

  localparam logic IRQ_LEVEL = 1'b0;
  localparam logic IRQ_EDGE  = 1'b1;

  // Bits [n-1:0] set; everything from n upwards is unimplemented.
  function automatic logic [NUM_IRQ-1:0] impl_mask(input int n);
    logic [NUM_IRQ-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_source_ctrl_edge_det.sv
// -----------------------------------------------------------------------------
// irq_edge_det
// Samples the raw interrupt source vector and produces the registered level
// and a one-cycle rising-edge indication per source.
//
// Optional build macro IRQ_SRC_SYNC_EN: when defined, src_i passes through a
// 2-flop synchronizer ahead of the sampling register (for sources that are
// asynchronous to clk). When undefined, src_i must be synchronous to clk.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   src_i    in   raw sources [NUM_SRC-1:0]
//   src_q_o  out  registered source levels
//   rise_o   out  src_q & ~prev_q (rising edge seen on the registered level)
// -----------------------------------------------------------------------------
module irq_edge_det #(
  parameter int NUM_SRC = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [NUM_SRC-1:0] src_q_o,
  output logic [NUM_SRC-1:0] rise_o
);

  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_prev_q;
  logic [NUM_SRC-1:0] w_src_in;

`ifdef IRQ_SRC_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src_in = r_sync2;
`else
  assign w_src_in = src_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_q  <= '0;
      r_prev_q <= '0;
    end else begin
      r_src_q  <= w_src_in;
      r_prev_q <= r_src_q;
    end
  end

  assign src_q_o = r_src_q;
  assign rise_o  = r_src_q & ~r_prev_q;

endmodule

// File: rtl/irq_source_ctrl.sv
// -----------------------------------------------------------------------------
// irq_source_ctrl
// Interrupt aggregator in front of the core interrupt port. Conditions each
// raw source as level or rising-edge, keeps edge pending / lost-edge state,
// and retires edge interrupts on core acknowledge.
//
// Optional build macro IRQ_SRC_SYNC_EN (see irq_edge_det): adds a 2-flop
// input synchronizer, raising source-to-pending latency by two cycles.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   src_i        in   raw peripheral sources [NUM_SRC-1:0], active-high
//   cfg_we_i     in   config write strobe (one cycle)
//   cfg_sel_i    in   0 ENABLE, 1 MODE, 2 PEND_SET (W1S), 3 PEND_CLR (W1C)
//   cfg_wdata_i  in   config write data
//   irq_ack_i    in   core acknowledge pulse
//   irq_id_i     in   index of taken interrupt
//   irq_o        out  pending & enable, to core irq_i
//   pending_o    out  raw pending vector
//   overflow_o   out  sticky lost-edge flags
// -----------------------------------------------------------------------------
module irq_source_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC      = 32,
  parameter logic [NUM_IRQ-1:0] RESET_ENABLE = 32'h0000_0000,
  parameter logic [NUM_IRQ-1:0] RESET_MODE   = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  src_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_sel_i,
  input  logic [NUM_IRQ-1:0]  cfg_wdata_i,
  input  logic                irq_ack_i,
  input  logic [IRQ_ID_W-1:0] irq_id_i,
  output logic [NUM_IRQ-1:0]  irq_o,
  output logic [NUM_IRQ-1:0]  pending_o,
  output logic [NUM_IRQ-1:0]  overflow_o
);

  localparam logic [NUM_IRQ-1:0] IMPL = impl_mask(NUM_SRC);

  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_overflow;

  logic [NUM_SRC-1:0] w_src_n;
  logic [NUM_SRC-1:0] w_rise_n;
  logic [NUM_IRQ-1:0] w_src_q;
  logic [NUM_IRQ-1:0] w_rise;

  logic               w_wr_enable;
  logic               w_wr_mode;
  logic               w_wr_pset;
  logic               w_wr_pclr;
  logic [NUM_IRQ-1:0] w_ack_clr;
  logic [NUM_IRQ-1:0] w_pclr_bits;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_edge_mask;
  logic [NUM_IRQ-1:0] w_pend_edge;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [NUM_IRQ-1:0] w_ovf_nxt;

  irq_edge_det #(
    .NUM_SRC (NUM_SRC)
  ) u_edge_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .src_i   (src_i),
    .src_q_o (w_src_n),
    .rise_o  (w_rise_n)
  );

  assign w_src_q = NUM_IRQ'(w_src_n);
  assign w_rise  = NUM_IRQ'(w_rise_n);

  always_comb begin
    w_wr_enable = 1'b0;
    w_wr_mode   = 1'b0;
    w_wr_pset   = 1'b0;
    w_wr_pclr   = 1'b0;
    if (cfg_we_i) begin
      case (cfg_sel_e'(cfg_sel_i))
        CFG_ENABLE:   w_wr_enable = 1'b1;
        CFG_MODE:     w_wr_mode   = 1'b1;
        CFG_PEND_SET: w_wr_pset   = 1'b1;
        CFG_PEND_CLR: w_wr_pclr   = 1'b1;
        default:      ;
      endcase
    end
  end

  // Acks naming an unimplemented index are dropped.
  always_comb begin
    w_ack_clr = '0;
    if (irq_ack_i && (int'(irq_id_i) < NUM_SRC)) begin
      w_ack_clr[irq_id_i] = 1'b1;
    end
  end

  assign w_edge_mask = (IRQ_EDGE == 1'b1) ? r_mode : ~r_mode;
  assign w_pclr_bits = w_wr_pclr ? cfg_wdata_i : '0;
  assign w_set       = w_rise | (w_wr_pset ? cfg_wdata_i : '0);
  assign w_clr       = w_ack_clr | w_pclr_bits;

  // Set beats clear so an edge arriving alongside an ack is not lost.
  assign w_pend_edge = w_set | (r_pending & ~w_clr);
  assign w_pend_nxt  = ((w_edge_mask & w_pend_edge) | (~w_edge_mask & w_src_q)) & IMPL;

  // A lost edge is a rise on an already-pending bit that is not being retired
  // this cycle; an explicit PEND_CLR of the bit wins over a simultaneous loss.
  assign w_ovf_nxt = (r_overflow | (w_edge_mask & w_rise & r_pending & ~w_clr))
                     & ~w_pclr_bits & IMPL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable   <= RESET_ENABLE & IMPL;
      r_mode     <= RESET_MODE & IMPL;
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      if (w_wr_enable) r_enable <= cfg_wdata_i & IMPL;
      if (w_wr_mode)   r_mode   <= cfg_wdata_i & IMPL;
      r_pending  <= w_pend_nxt;
      r_overflow <= w_ovf_nxt;
    end
  end

  assign irq_o      = r_pending & r_enable;
  assign pending_o  = r_pending;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_irq_source_ctrl.sv
module tb_irq_source_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [31:0] cfg_wdata = '0;
  logic        ack = 1'b0;
  logic [4:0]  ack_id = '0;
  logic [31:0] irq, pend, ovf;

  irq_source_ctrl #(
    .NUM_SRC      (32),
    .RESET_ENABLE (32'h0000_0000),
    .RESET_MODE   (32'hFFFF_FFFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_i       (src),
    .cfg_we_i    (cfg_we),
    .cfg_sel_i   (cfg_sel),
    .cfg_wdata_i (cfg_wdata),
    .irq_ack_i   (ack),
    .irq_id_i    (ack_id),
    .irq_o       (irq),
    .pending_o   (pend),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          at;
    logic [31:0] irq;
    logic [31:0] pend;
    logic [31:0] ovf;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected outputs are due at the falling edge of cycle cyc+d.
  task automatic exp_push(input string nm, input int d, input logic [31:0] e_irq,
                          input logic [31:0] e_pend, input logic [31:0] e_ovf);
    exp_t e;
    e.name = nm;
    e.at   = cyc + d;
    e.irq  = e_irq;
    e.pend = e_pend;
    e.ovf  = e_ovf;
    sb.push_back(e);
  endtask

  // Monitor: retires scoreboard entries whose cycle has come up.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: check due at cycle %0d missed, now %0d", e.name, e.at, cyc);
      end else begin
        chk({e.name, ".irq"},  irq,  e.irq);
        chk({e.name, ".pend"}, pend, e.pend);
        chk({e.name, ".ovf"},  ovf,  e.ovf);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic do_ack(input logic [4:0] id);
    ack    = 1'b1;
    ack_id = id;
    step(1);
    ack    = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d expectations never retired", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    exp_push("reset", 0, 32'h0, 32'h0, 32'h0);

    // Edge source, two-cycle latency, ack retires it
    cfg(CFG_ENABLE, 32'h0000_0888);
    src[11] = 1'b1;
    exp_push("t1_lat1", 1, 32'h0, 32'h0, 32'h0);
    exp_push("t1_lat2", 2, 32'h800, 32'h800, 32'h0);
    step(2);
    do_ack(5'd11);
    exp_push("t1_ack", 0, 32'h0, 32'h0, 32'h0);
    src[11] = 1'b0;
    step(2);

    // Level source ignores ack, follows source
    cfg(CFG_MODE, 32'hFFFF_FF7F);
    src[7] = 1'b1;
    step(2);
    exp_push("t2_level", 0, 32'h80, 32'h80, 32'h0);
    do_ack(5'd7);
    exp_push("t2_ack_level", 0, 32'h80, 32'h80, 32'h0);
    src[7] = 1'b0;
    exp_push("t2_fall1", 1, 32'h80, 32'h80, 32'h0);
    exp_push("t2_fall2", 2, 32'h0, 32'h0, 32'h0);
    step(2);

    // Second rise while pending sets overflow; PEND_CLR clears both
    cfg(CFG_MODE, 32'hFFFF_FFFF);
    src[16] = 1'b1;
    step(2);
    exp_push("t3_pend", 0, 32'h0, 32'h0001_0000, 32'h0);
    src[16] = 1'b0;
    step(1);
    src[16] = 1'b1;
    exp_push("t3_ovf", 2, 32'h0, 32'h0001_0000, 32'h0001_0000);
    step(2);
    cfg(CFG_PEND_CLR, 32'h0001_0000);
    exp_push("t3_clr", 0, 32'h0, 32'h0, 32'h0);
    step(1);

    // Rise coinciding with ack: set wins, no overflow
    cfg(CFG_PEND_SET, 32'h0000_0008);
    exp_push("t4_pset", 0, 32'h8, 32'h8, 32'h0);
    src[3] = 1'b1;
    step(1);
    do_ack(5'd3);
    exp_push("t4_set_wins", 0, 32'h8, 32'h8, 32'h0);
    exp_push("t4_hold", 1, 32'h8, 32'h8, 32'h0);
    step(1);
    do_ack(5'd3);
    exp_push("t4_ack", 0, 32'h0, 32'h0, 32'h0);
    src[3] = 1'b0;
    step(2);

    // Masking, enabling pending bits, ack of top bit
    cfg(CFG_ENABLE, 32'h0);
    cfg(CFG_PEND_SET, 32'hFFFF_0000);
    exp_push("t5_masked", 0, 32'h0, 32'hFFFF_0000, 32'h0);
    cfg(CFG_ENABLE, 32'hFFFF_FFFF);
    exp_push("t5_enable", 0, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0);
    do_ack(5'd31);
    exp_push("t5_ack31", 0, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
    step(1);

    // Asynchronous reset while pending
    cfg(CFG_PEND_CLR, 32'hFFFF_FFFF);
    cfg(CFG_ENABLE, 32'h0000_0080);
    cfg(CFG_PEND_SET, 32'h0000_0080);
    exp_push("t6_pre", 0, 32'h80, 32'h80, 32'h0);
    step(1);
    drain("t6_drain");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async.irq",  irq,  32'h0);
    chk("t6_async.pend", pend, 32'h0);
    chk("t6_async.ovf",  ovf,  32'h0);
    src[16] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_push("t6_after", 0, 32'h0, 32'h0, 32'h0);
    cfg(CFG_PEND_SET, 32'h0000_0001);
    exp_push("t6_rst_enable", 0, 32'h0, 32'h1, 32'h0);
    step(1);

    drain("final_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
- Upstream interrupt aggregator directly in front of the core interrupt port.
- Collects raw peripheral interrupt sources and conditions each as level or rising-edge.
- Holds edge-type pending state and drives the 32-bit core interrupt input vector.
- Retires pending edge interrupts when the core returns acknowledge plus taken-interrupt index.

Parameters:
- NUM_SRC, 32, number of implemented sources (1..32); bits at NUM_SRC and above tie to 0.
- RESET_ENABLE, 32'h0000_0000, enable mask value after reset.
- RESET_MODE, 32'hFFFF_FFFF, per-source mode after reset (1 = edge, 0 = level).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- src_i  in  NUM_SRC  raw peripheral interrupt sources, active-high.
- cfg_we_i  in  1  config write strobe, one cycle.
- cfg_sel_i  in  2  0 = ENABLE write, 1 = MODE write, 2 = PEND_SET (W1S), 3 = PEND_CLR (W1C).
- cfg_wdata_i  in  32  config write data.
- irq_ack_i  in  1  core acknowledge pulse (core irq_ack_o).
- irq_id_i  in  5  index of taken interrupt (core irq_id_o).
- irq_o  out  32  to core irq_i.
- pending_o  out  32  raw pending vector, before masking.
- overflow_o  out  32  sticky lost-edge flags.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pending_q = 0, overflow_q = 0.
  - enable_q = RESET_ENABLE, mode_q = RESET_MODE.
  - Edge-detect history = 0.
  - Consequently irq_o = 0, pending_o = 0, overflow_o = 0.
  - Reset mid-operation discards all pending state; no ack is required afterwards.
- Sampling: src_i registered once into src_q every cycle; prev_q holds the previous src_q.
  - rise[i] = src_q[i] & ~prev_q[i].
- Level source (mode_q[i] = 0):
  - pending_q[i] <= src_q[i] each cycle.
  - Ack and PEND_SET/PEND_CLR have no effect on it.
  - Overflow is never set.
- Edge source (mode_q[i] = 1), next-state priority, highest first:
  - set = rise[i], or PEND_SET write with wdata[i] = 1.
  - clr = irq_ack_i with irq_id_i == i, or PEND_CLR write with wdata[i] = 1.
  - set wins over clr in the same cycle, so the new event is retained.
  - Otherwise pending_q[i] holds.
- Overflow (edge sources):
  - overflow_q[i] sets when rise[i] occurs while pending_q[i] = 1 and no clr hits bit i that cycle.
  - overflow_q[i] clears only by a PEND_CLR write with wdata[i] = 1. Clearing at that moment takes priority over a new overflow.
- Output: irq_o = pending_q & enable_q, driven from registers with no combinational path from src_i.
- Latency: src_i rising at edge N → pending_q at edge N+2 → irq_o valid after edge N+2.
- Ack: irq_ack_i is a single-cycle pulse sampled at the clock edge.
  - irq_id_i >= NUM_SRC: ignored.
  - Ack of a disabled bit still clears it.
  - Deasserted irq_o is visible the cycle after ack.
- Config writes:
  - Take effect at the clock edge.
  - ENABLE and MODE bits at NUM_SRC and above are written as 0.
  - MODE change level → edge: pending_q[i] keeps its current value and prev_q is not reset, so no spurious edge.
  - MODE change edge → level: pending_q[i] follows src_q from the next cycle.
- Disabled sources still accumulate pending and overflow; enabling a pending bit asserts irq_o the next cycle.

Optional Feature:
- Macro: IRQ_SRC_SYNC_EN.
- Defined: src_i passes through a 2-flop synchronizer before src_q, for asynchronous sources. Latency becomes N+4. Synchronizer flops reset to 0.
- Undefined: single sampling register only; src_i must be synchronous to clk.

Decomposition:
- Package irq_ctrl_pkg:
  - NUM_IRQ = 32 and IRQ_ID_W = 5.
  - cfg_sel_e enum: CFG_ENABLE, CFG_MODE, CFG_PEND_SET, CFG_PEND_CLR.
  - Mode constants IRQ_LEVEL and IRQ_EDGE.
- Sub-module irq_edge_det: holds the optional synchronizer, src_q, prev_q and rise for a NUM_SRC-wide vector. The top level holds the config registers, pending and overflow logic.

Test Plan:
- Reset, then ENABLE = 32'h0000_0888, src_i[11] 0→1 → pending_o = 32'h800 and irq_o = 32'h800 two cycles later. Ack with id 11 → irq_o = 0 the next cycle.
- MODE = 0 (level) for bit 7, src_i[7] held high, ack with id 7 → irq_o[7] stays 1. src_i[7] low → irq_o[7] = 0 two cycles later.
- Edge bit 16 pending, second rise on bit 16 before ack → overflow_o = 32'h0001_0000. PEND_CLR wdata = 32'h0001_0000 → pending and overflow both 0.
- rise on bit 3 in the same cycle as ack id 3 → pending_o[3] = 1 remains (set wins), overflow_o[3] = 0.
- ENABLE = 0, PEND_SET wdata = 32'hFFFF_0000 → irq_o = 0, pending_o = FFFF_0000. ENABLE = FFFF_FFFF → irq_o = FFFF_0000 the next cycle. Ack id 31 → irq_o = 7FFF_0000.
- rst_n asserted low mid-pending (irq_o = 32'h80) → irq_o, pending_o and overflow_o = 0 immediately, without waiting for a clock edge.
